// File: rtl/sram16_dram_responder.sv
// Executes one 32-bit MCU DRAM request as up to two 16-bit async-SRAM accesses, then pulses dram_ack.
// Optional one-entry read buffer enabled by defining DRAM_RESP_RD_BUF_EN.
module sram16_dram_responder #(
    parameter int ADDR_BITS   = 22,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic [ADDR_BITS-1:0] dram_mem_addr,
    input  logic                 dram_mem_read_en,
    input  logic                 dram_mem_write_en,
    input  logic [3:0]           dram_mem_byte_enable,
    input  logic [31:0]          dram_mem_write_data,
    output logic                 dram_ack,
    output logic [31:0]          dram_mem_read_data,
    output logic [ADDR_BITS:0]   sram_addr,
    output logic [15:0]          sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [15:0]          sram_dq_in,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC_LO = 2'd1, ACC_HI = 2'd2, DONE = 2'd3} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt;
    logic                   phase_end;
    logic                   in_acc;
    logic                   req_wr;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [3:0]             req_be;
    logic [31:0]            req_wdata;
    logic                   accept;
    logic                   hit;
    logic [ADDR_BITS-1:0]   cur_addr;
    logic [31:0]            cur_wdata;
    logic                   cur_wr;

    assign phase_end = (cnt == 4'(WAIT_CYCLES));
    assign in_acc    = (state == ACC_LO) || (state == ACC_HI);
    assign accept    = (state == IDLE) && (dram_mem_read_en || dram_mem_write_en);
    assign dbg_state = state;

    // Phase address/data come straight from the request port when launching from IDLE.
    assign cur_addr  = (state == IDLE) ? dram_mem_addr       : req_addr;
    assign cur_wdata = (state == IDLE) ? dram_mem_write_data : req_wdata;
    assign cur_wr    = (state == IDLE) ? dram_mem_write_en   : req_wr;

`ifdef DRAM_RESP_RD_BUF_EN
    logic                 buf_valid;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [31:0]          buf_data;

    assign hit = buf_valid && (buf_addr == dram_mem_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (sync_reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (state == ACC_HI && !req_wr && phase_end) begin
            buf_valid <= 1'b1;
            buf_addr  <= req_addr;
            buf_data  <= {sram_dq_in, dram_mem_read_data[15:0]};
        end else if (state == IDLE && dram_mem_write_en && (|dram_mem_byte_enable) && hit) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dram_mem_write_en) begin
                    if (|dram_mem_byte_enable[1:0])      state_nxt = ACC_LO;
                    else if (|dram_mem_byte_enable[3:2]) state_nxt = ACC_HI;
                    else                                 state_nxt = DONE;
                end else if (dram_mem_read_en) begin
                    state_nxt = hit ? DONE : ACC_LO;
                end
            end
            ACC_LO: if (phase_end) state_nxt = (!req_wr || (|req_be[3:2])) ? ACC_HI : DONE;
            ACC_HI: if (phase_end) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes pulse we_n low for WAIT_CYCLES clocks, leaving the last clock of the phase as hold.
    always_comb begin
        dram_ack   = (state == DONE);
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        if (in_acc) begin
            sram_ce_n = 1'b0;
            if (req_wr) begin
                sram_dq_oe = 1'b1;
                sram_we_n  = phase_end;
                sram_lb_n  = (state == ACC_HI) ? ~req_be[2] : ~req_be[0];
                sram_ub_n  = (state == ACC_HI) ? ~req_be[3] : ~req_be[1];
            end else begin
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            req_wr             <= 1'b0;
            req_addr           <= '0;
            req_be             <= '0;
            req_wdata          <= '0;
            dram_mem_read_data <= '0;
            sram_addr          <= '0;
            sram_dq_out        <= '0;
        end else if (sync_reset) begin
            state              <= IDLE;
            cnt                <= '0;
            req_wr             <= 1'b0;
            req_addr           <= '0;
            req_be             <= '0;
            req_wdata          <= '0;
            dram_mem_read_data <= '0;
            sram_addr          <= '0;
            sram_dq_out        <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (in_acc && !phase_end) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                req_wr    <= dram_mem_write_en;
                req_addr  <= dram_mem_addr;
                req_be    <= dram_mem_byte_enable;
                req_wdata <= dram_mem_write_data;
            end
            if (state_nxt == ACC_LO && state != ACC_LO) begin
                sram_addr <= {cur_addr, 1'b0};
                if (cur_wr) sram_dq_out <= cur_wdata[15:0];
            end
            if (state_nxt == ACC_HI && state != ACC_HI) begin
                sram_addr <= {cur_addr, 1'b1};
                if (cur_wr) sram_dq_out <= cur_wdata[31:16];
            end
            if (in_acc && !req_wr && phase_end) begin
                if (state == ACC_LO) dram_mem_read_data[15:0]  <= sram_dq_in;
                else                 dram_mem_read_data[31:16] <= sram_dq_in;
            end
`ifdef DRAM_RESP_RD_BUF_EN
            if (state == IDLE && !dram_mem_write_en && dram_mem_read_en && hit)
                dram_mem_read_data <= buf_data;
`endif
        end
    end

endmodule
